// File: rtl/bsg_fma_pkg.sv
// Shared definitions for the FMA integer slice (MULH and IDIV units).
// Latency: n/a (types, parameters and helper functions only).
// Backpressure: n/a.
package bsg_fma_pkg;

  localparam int exp_default_lp = 8;
  localparam int sig_default_lp = 24;

  // Integer divider sequencing states.
  typedef enum logic [2:0] {
    eIdle,
    eNorm,
    eCalc,
    eFix,
    eDone
  } divstate_e;

  // Integer word width is the full FP word (exponent + significand).
  function automatic int bsg_fma_width(input int exp_w, input int sig_w);
    return exp_w + sig_w;
  endfunction

endpackage

// File: rtl/bsg_fma_idiv_if.sv
// Request/response bundle for the integer divide/remainder unit.
// Latency: n/a (wires only).
// Backpressure: request side valid/ready, response side valid/yumi.
interface bsg_fma_idiv_if
  import bsg_fma_pkg::*;
#(
  parameter int width_p = bsg_fma_width(exp_default_lp, sig_default_lp)
);

  logic [width_p-1:0] opA_i;
  logic [width_p-1:0] opB_i;
  logic               signed_i;
  logic               rem_i;
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] res_o;
  logic               v_o;
  logic               yumi_i;

  // Requester/consumer side.
  modport master (
    output opA_i, opB_i, signed_i, rem_i, v_i, yumi_i,
    input  ready_o, res_o, v_o
  );

  // Divider side.
  modport slave (
    input  opA_i, opB_i, signed_i, rem_i, v_i, yumi_i,
    output ready_o, res_o, v_o
  );

endinterface

// File: rtl/bsg_fma_cond_neg.sv
// Conditional two's-complement negate: o = neg_i ? -a_i : a_i.
// Latency: combinational.
// Backpressure: none.
module bsg_fma_cond_neg #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] a_i,
  input  logic               neg_i,
  output logic [width_p-1:0] o
);

  // -2^(w-1) maps onto itself, which read as unsigned is its magnitude.
  assign o = neg_i ? (width_p'(0) - a_i) : a_i;

endmodule

// File: rtl/bsg_fma_idiv.sv
// Radix-2 restoring integer divide/remainder, signed or unsigned.
// Latency: v_o rises width_lp+2 edges after accept, independent of operands.
// Backpressure: ready_o only in idle; result held until yumi_i, no overlap.
module bsg_fma_idiv
  import bsg_fma_pkg::*;
#(
  parameter int exp_p = exp_default_lp,
  parameter int sig_p = sig_default_lp
) (
  input  logic           clk_i,
  input  logic           reset_i,
  bsg_fma_idiv_if.slave  io
);

  localparam int width_lp = bsg_fma_width(exp_p, sig_p);
  localparam int cnt_w_lp = $clog2(width_lp);

  divstate_e             state_r;
  logic [width_lp-1:0]   opa_r;
  logic [width_lp-1:0]   opb_r;
  logic [width_lp-1:0]   bmag_r;
  logic [width_lp-1:0]   q_r;
  logic [width_lp:0]     rem_r;
  logic [width_lp-1:0]   res_r;
  logic [cnt_w_lp-1:0]   cnt_r;
  logic                  neg_a_r;
  logic                  neg_b_r;
  logic                  rem_sel_r;
  logic                  zero_div_r;
  logic                  ready_r;
  logic                  v_r;

  // Two shared negators: operand magnitudes in eNorm, sign fix-up in eFix.
  logic [width_lp-1:0]   neg0_a, neg0_o;
  logic [width_lp-1:0]   neg1_a, neg1_o;
  logic                  neg0_n, neg1_n;

  // Route operands through the negators in eNorm, results otherwise.
  always_comb begin
    neg0_a = q_r;
    neg0_n = neg_a_r ^ neg_b_r;
    neg1_a = rem_r[width_lp-1:0];
    neg1_n = neg_a_r;
    if (state_r == eNorm) begin
      neg0_a = opa_r;
      neg0_n = neg_a_r;
      neg1_a = opb_r;
      neg1_n = neg_b_r;
    end
  end

  bsg_fma_cond_neg #(.width_p(width_lp)) neg0 (
    .a_i   (neg0_a),
    .neg_i (neg0_n),
    .o     (neg0_o)
  );

  bsg_fma_cond_neg #(.width_p(width_lp)) neg1 (
    .a_i   (neg1_a),
    .neg_i (neg1_n),
    .o     (neg1_o)
  );

  // One trial subtraction per iteration. The partial remainder stays below
  // |B| < 2^w, so after the shift it always fits width_lp+1 bits; the extra
  // top bit of diff is the sign that decides the quotient bit.
  logic [width_lp+1:0]   shift_rem;
  logic [width_lp+1:0]   diff;
  logic                  q_bit;

  assign shift_rem = {rem_r, q_r[width_lp-1]};
  assign diff      = shift_rem - {2'b00, bmag_r};
  assign q_bit     = ~diff[width_lp+1];

  // Sequencer and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= eIdle;
      opa_r      <= '0;
      opb_r      <= '0;
      bmag_r     <= '0;
      q_r        <= '0;
      rem_r      <= '0;
      res_r      <= '0;
      cnt_r      <= '0;
      neg_a_r    <= 1'b0;
      neg_b_r    <= 1'b0;
      rem_sel_r  <= 1'b0;
      zero_div_r <= 1'b0;
      ready_r    <= 1'b1;
      v_r        <= 1'b0;
    end else begin
      case (state_r)
        eIdle: begin
          if (io.v_i) begin
            opa_r     <= io.opA_i;
            opb_r     <= io.opB_i;
            neg_a_r   <= io.signed_i & io.opA_i[width_lp-1];
            neg_b_r   <= io.signed_i & io.opB_i[width_lp-1];
            rem_sel_r <= io.rem_i;
            ready_r   <= 1'b0;
            state_r   <= eNorm;
          end
        end
        eNorm: begin
          q_r        <= neg0_o;
          bmag_r     <= neg1_o;
          zero_div_r <= (opb_r == '0);
          rem_r      <= '0;
          cnt_r      <= cnt_w_lp'(width_lp - 1);
          state_r    <= eCalc;
        end
        eCalc: begin
          q_r   <= {q_r[width_lp-2:0], q_bit};
          rem_r <= q_bit ? diff[width_lp:0] : shift_rem[width_lp:0];
          if (cnt_r == '0) begin
            state_r <= eFix;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        eFix: begin
          if (rem_sel_r) begin
            res_r <= zero_div_r ? opa_r : neg1_o;
          end else begin
            res_r <= zero_div_r ? '1 : neg0_o;
          end
          v_r     <= 1'b1;
          state_r <= eDone;
        end
        eDone: begin
          if (io.yumi_i) begin
            v_r     <= 1'b0;
            ready_r <= 1'b1;
            state_r <= eIdle;
          end
        end
        default: begin
          v_r     <= 1'b0;
          ready_r <= 1'b1;
          state_r <= eIdle;
        end
      endcase
    end
  end

  assign io.ready_o = ready_r;
  assign io.v_o     = v_r;
  assign io.res_o   = res_r;

endmodule

// File: tb/tb_bsg_fma_idiv.sv
// Scoreboard bench for bsg_fma_idiv: directed corner cases plus random ops.
// Latency: result expected exactly 34 edges after accept.
// Backpressure: consumer holds yumi_i off for a per-transaction delay.
module tb_bsg_fma_idiv;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_fma_idiv_if #(.width_p(W)) dif ();

  bsg_fma_idiv #(.exp_p(8), .sig_p(24)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (dif)
  );

  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           hold_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic r);
    longint sa, sb, q, m;
    if (b == '0) return r ? a : '1;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    q = sa / sb;
    m = sa % sb;
    return r ? m[W-1:0] : q[W-1:0];
  endfunction

  // Issue one request from a negedge; returns at the negedge after accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic r, input int hold, input bit expect_res);
    int k;
    k = 0;
    while (dif.ready_o !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (dif.ready_o !== 1'b1) begin
      check("ready_wait", dif.ready_o, 1'b1);
      return;
    end
    dif.opA_i    = a;
    dif.opB_i    = b;
    dif.signed_i = s;
    dif.rem_i    = r;
    dif.v_i      = 1'b1;
    @(posedge clk);
    #1;
    if (expect_res) begin
      exp_q.push_back(model(a, b, s, r));
      acc_q.push_back(cyc);
      hold_q.push_back(hold);
    end
    @(negedge clk);
    dif.v_i = 1'b0;
  endtask

  // Monitor: pop and compare whenever a result is presented.
  initial begin
    logic [W-1:0] e;
    int a, h;
    forever begin
      @(negedge clk);
      if (!reset_i && dif.v_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_v_o", dif.v_o, 1'b0);
          e = dif.res_o;
          h = 0;
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          h = hold_q.pop_front();
          check("latency", W'(cyc - a), W'(LAT));
        end
        for (int i = 0; i < h; i++) begin
          check("hold_res", dif.res_o, e);
          check("hold_ready", dif.ready_o, 1'b0);
          @(negedge clk);
          check("hold_v", dif.v_o, 1'b1);
        end
        check("result", dif.res_o, e);
        dif.yumi_i = 1'b1;
        @(negedge clk);
        dif.yumi_i = 1'b0;
        check("ready_after_yumi", dif.ready_o, 1'b1);
        check("v_after_yumi", dif.v_o, 1'b0);
      end
    end
  end

  // Watchdog: always reach the summary.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no completion, expected finish by cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         r;
    int           hold;
  } vec_t;

  vec_t dirs[$];

  initial begin
    logic [W-1:0] a, b;
    int k;
    dif.opA_i = '0; dif.opB_i = '0; dif.signed_i = 1'b0; dif.rem_i = 1'b0;
    dif.v_i = 1'b0; dif.yumi_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", dif.ready_o, 1'b1);
    check("reset_v", dif.v_o, 1'b0);
    check("reset_res", dif.res_o, '0);
    reset_i = 1'b0;
    @(negedge clk);

    dirs.push_back('{32'd100, 32'd7, 1'b0, 1'b0, 0});
    dirs.push_back('{32'd100, 32'd7, 1'b0, 1'b1, 0});
    dirs.push_back('{-32'sd7, 32'd2, 1'b1, 1'b0, 0});
    dirs.push_back('{-32'sd7, 32'd2, 1'b1, 1'b1, 0});
    dirs.push_back('{32'd7, -32'sd2, 1'b1, 1'b1, 0});
    dirs.push_back('{32'h80000005, 32'd0, 1'b1, 1'b0, 0});
    dirs.push_back('{32'h80000005, 32'd0, 1'b1, 1'b1, 0});
    dirs.push_back('{32'd5, 32'd0, 1'b0, 1'b0, 0});
    dirs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 0});
    dirs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 0});
    dirs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 0});
    dirs.push_back('{32'd1000, 32'd33, 1'b0, 1'b0, 10});
    foreach (dirs[i]) issue(dirs[i].a, dirs[i].b, dirs[i].s, dirs[i].r, dirs[i].hold, 1'b1);

    // v_i pulsed mid-calculation must be ignored.
    issue(32'd123456, 32'd789, 1'b0, 1'b0, 0, 1'b1);
    repeat (12) @(negedge clk);
    check("busy_ready", dif.ready_o, 1'b0);
    dif.opA_i = 32'd5; dif.opB_i = 32'd1; dif.rem_i = 1'b1; dif.v_i = 1'b1;
    @(negedge clk);
    dif.v_i = 1'b0;

    // Reset in the middle of eCalc discards the operation.
    issue(32'd77777, 32'd3, 1'b0, 1'b0, 0, 1'b0);
    repeat (11) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check("midreset_ready", dif.ready_o, 1'b1);
    check("midreset_v", dif.v_o, 1'b0);
    reset_i = 1'b0;
    @(negedge clk);
    issue(32'd9, 32'd3, 1'b0, 1'b0, 0, 1'b1);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      k = $urandom_range(0, 7);
      case (k)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = W'(0) - W'($urandom_range(1, 15));
        3: b = 32'hFFFFFFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'b1);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("drain", W'(exp_q.size()), '0);
    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
